// File: rtl/hex_display_scan.sv
// hex_display_scan: time-multiplexed driver for NUM_DIGITS common-anode
// 7-segment digits sharing one segment bus. A captured value is scanned
// digit by digit. Zero blanking, leading-zero suppression and per-digit
// blinking are applied while each digit is selected.
module hex_display_scan #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    show_zero,
    input  logic                    lz_suppress,
    input  logic [NUM_DIGITS-1:0]   blink_en,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FRM_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FRM_W-1:0]  FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);
    localparam logic [6:0]        BLANK     = 7'b1111111;

    // Segment pattern for one hex nibble, {g,f,e,d,c,b,a}, active low.
    function automatic logic [6:0] hex_code(input logic [3:0] nib);
        case (nib)
            4'h0:    hex_code = 7'b1000000;
            4'h1:    hex_code = 7'b1111001;
            4'h2:    hex_code = 7'b0100100;
            4'h3:    hex_code = 7'b0110000;
            4'h4:    hex_code = 7'b0011001;
            4'h5:    hex_code = 7'b0010010;
            4'h6:    hex_code = 7'b0000010;
            4'h7:    hex_code = 7'b1111000;
            4'h8:    hex_code = 7'b0000000;
            4'h9:    hex_code = 7'b0010000;
            4'hA:    hex_code = 7'b0001000;
            4'hB:    hex_code = 7'b0000011;
            4'hC:    hex_code = 7'b1000110;
            4'hD:    hex_code = 7'b0100001;
            4'hE:    hex_code = 7'b0000110;
            4'hF:    hex_code = 7'b0001110;
            default: hex_code = BLANK;
        endcase
    endfunction

    logic [4*NUM_DIGITS-1:0] value_reg, value_next;
    logic [SCAN_W-1:0]       scan_cnt_reg, scan_cnt_next;
    logic [IDX_W-1:0]        idx_reg, idx_next;
    logic [FRM_W-1:0]        frame_cnt_reg, frame_cnt_next;
    logic                    blink_phase_reg, blink_phase_next;
    logic [6:0]              seg_reg, seg_next;
    logic [NUM_DIGITS-1:0]   an_reg, an_next;
    logic                    frame_tick_reg, frame_tick_next;

    logic                    scan_terminal;
    logic                    index_wrap;

    logic [6:0]              digit_seg [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   an_sel;

    // Per-digit segment pattern with all blanking rules folded in, plus
    // the one-hot-low anode pattern for each possible index.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic [3:0] nib;
            logic       nib_zero;
            logic       upper_zero;
            logic       lz_blank;
            logic       digit_blank;

            assign nib      = value_reg[4*gi +: 4];
            assign nib_zero = (nib == 4'h0);

            // This digit and everything above it are zero.
            assign upper_zero = (value_reg[4*NUM_DIGITS-1 : 4*gi] == '0);

            // Digit 0 is never a leading zero, so a zero value still
            // shows a single "0" when zeros are displayed.
            if (gi > 0) begin : g_lz
                assign lz_blank = lz_suppress & upper_zero;
            end else begin : g_no_lz
                assign lz_blank = 1'b0;
            end

            assign digit_blank = (nib_zero & ~show_zero)
                               | lz_blank
                               | (blink_en[gi] & blink_phase_reg);

            assign digit_seg[gi] = digit_blank ? BLANK : hex_code(nib);
            assign an_sel[gi]    = (idx_reg != IDX_W'(gi));
        end
    endgenerate

    // Scan, frame and blink sequencing plus value capture.
    always_comb begin
        scan_terminal    = (scan_cnt_reg == SCAN_LAST);
        index_wrap       = scan_terminal && (idx_reg == IDX_LAST);

        value_next       = load ? value : value_reg;
        scan_cnt_next    = scan_terminal ? '0 : scan_cnt_reg + SCAN_W'(1);
        idx_next         = idx_reg;
        frame_cnt_next   = frame_cnt_reg;
        blink_phase_next = blink_phase_reg;
        frame_tick_next  = index_wrap;

        if (scan_terminal) begin
            idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
        end

        if (index_wrap) begin
            if (frame_cnt_reg == FRM_LAST) begin
                frame_cnt_next   = '0;
                blink_phase_next = ~blink_phase_reg;
            end else begin
                frame_cnt_next = frame_cnt_reg + FRM_W'(1);
            end
        end
    end

    // Output selection for the currently indexed digit.
    always_comb begin
        seg_next = BLANK;
        an_next  = an_sel;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_reg == IDX_W'(i)) begin
                seg_next = digit_seg[i];
            end
        end
    end

    // State and output registers; reset blanks the display immediately.
    always_ff @(posedge clk) begin
        if (reset) begin
            value_reg       <= '0;
            scan_cnt_reg    <= '0;
            idx_reg         <= '0;
            frame_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
            seg_reg         <= BLANK;
            an_reg          <= '1;
            frame_tick_reg  <= 1'b0;
        end else begin
            value_reg       <= value_next;
            scan_cnt_reg    <= scan_cnt_next;
            idx_reg         <= idx_next;
            frame_cnt_reg   <= frame_cnt_next;
            blink_phase_reg <= blink_phase_next;
            seg_reg         <= seg_next;
            an_reg          <= an_next;
            frame_tick_reg  <= frame_tick_next;
        end
    end

    assign seg        = seg_reg;
    assign an         = an_reg;
    assign frame_tick = frame_tick_reg;

endmodule
